// File: rtl/fifo_param_if.sv
// Handshake/status bundle between a fifo_param lane queue and its demux/arbiter neighbours.
// master drives push/pop requests and thresholds; slave is the FIFO itself.
interface fifo_param_if #(
  parameter int DATA_SIZE = 10,
  parameter int ADDR_SIZE = 3
);
  logic                 write;
  logic                 read;
  logic [DATA_SIZE-1:0] data_in_push;
  logic [ADDR_SIZE:0]   umbral_full;
  logic [ADDR_SIZE:0]   umbral_empty;
  logic                 err_clear;
  logic [DATA_SIZE-1:0] data_out_pop;
  logic                 valid_out;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 almost_full;
  logic                 almost_empty;
  logic                 fifo_pause;
  logic                 fifo_error;
  logic [ADDR_SIZE:0]   count;

  modport master (
    output write, read, data_in_push, umbral_full, umbral_empty, err_clear,
    input  data_out_pop, valid_out, fifo_empty, fifo_full, almost_full,
           almost_empty, fifo_pause, fifo_error, count
  );

  modport slave (
    input  write, read, data_in_push, umbral_full, umbral_empty, err_clear,
    output data_out_pop, valid_out, fifo_empty, fifo_full, almost_full,
           almost_empty, fifo_pause, fifo_error, count
  );
endinterface

// File: rtl/fifo_param.sv
// Parametrised synchronous lane FIFO with programmable thresholds, hysteretic pause and sticky error.
// Define FIFO_FWFT_EN for first-word fall-through output; default is registered pop with latency 1.
module fifo_param #(
  parameter int DATA_SIZE = 10,
  parameter int ADDR_SIZE = 3
) (
  input logic          clk,
  input logic          reset,
  fifo_param_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] DEPTH_C = {1'b1, {ADDR_SIZE{1'b0}}};

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr, rd_ptr;
  logic [ADDR_SIZE:0]   count_q, count_next, full_thr;
  logic                 empty_c, full_c;
  logic                 push_acc, pop_acc, err_set;
  logic                 pause_q, error_q;

  // A zero almost-full threshold would assert permanently; treat it as DEPTH instead.
  assign full_thr = (bus.umbral_full == '0) ? DEPTH_C : bus.umbral_full;

  assign empty_c  = (count_q == '0);
  assign full_c   = (count_q == DEPTH_C);
  assign pop_acc  = bus.read && !empty_c;
  assign push_acc = bus.write && (!full_c || pop_acc);
  assign err_set  = (bus.write && full_c && !bus.read) || (bus.read && empty_c);

  assign count_next = count_q + {{ADDR_SIZE{1'b0}}, push_acc} - {{ADDR_SIZE{1'b0}}, pop_acc};

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= bus.data_in_push;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      pause_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + ADDR_SIZE'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + ADDR_SIZE'(1);
      count_q <= count_next;
      if (count_next >= full_thr)
        pause_q <= 1'b1;
      else if (count_next <= bus.umbral_empty)
        pause_q <= 1'b0;
      // A fresh error outranks a clear issued in the same cycle.
      if (err_set)
        error_q <= 1'b1;
      else if (bus.err_clear)
        error_q <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  assign bus.data_out_pop = empty_c ? '0 : mem[rd_ptr];
  assign bus.valid_out    = !empty_c;
`else
  logic [DATA_SIZE-1:0] dout_q;
  logic                 valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= pop_acc;
      if (pop_acc) dout_q <= mem[rd_ptr];
    end
  end

  assign bus.data_out_pop = dout_q;
  assign bus.valid_out    = valid_q;
`endif

  assign bus.count        = count_q;
  assign bus.fifo_empty   = empty_c;
  assign bus.fifo_full    = full_c;
  assign bus.almost_full  = (count_q >= full_thr);
  assign bus.almost_empty = (count_q <= bus.umbral_empty);
  assign bus.fifo_pause   = pause_q;
  assign bus.fifo_error   = error_q;
endmodule

// File: tb/tb_fifo_param.sv
// Directed + randomized bench for fifo_param against a queue-based reference model.
// Build with +define+FIFO_FWFT_EN to check the fall-through variant.
module tb_fifo_param;
  localparam int DW    = 10;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_param_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) bus ();
  fifo_param #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  int uf, ue;

  logic [DW-1:0] q[$];
  logic          m_err, m_pause, m_valid;
  logic [DW-1:0] m_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_err   = 1'b0;
    m_pause = 1'b0;
    m_valid = 1'b0;
    m_dout  = '0;
  endtask

  task automatic set_thr(input int f, input int e);
    uf = f;
    ue = e;
    bus.umbral_full  = 4'(f);
    bus.umbral_empty = 4'(e);
  endtask

  task automatic check_all(input string tag);
    int c;
    int fthr;
    c    = q.size();
    fthr = (uf == 0) ? DEPTH : uf;
    chk({tag, ":count"},        32'(bus.count),        32'(c));
    chk({tag, ":fifo_empty"},   32'(bus.fifo_empty),   32'(c == 0));
    chk({tag, ":fifo_full"},    32'(bus.fifo_full),    32'(c == DEPTH));
    chk({tag, ":almost_full"},  32'(bus.almost_full),  32'(c >= fthr));
    chk({tag, ":almost_empty"}, 32'(bus.almost_empty), 32'(c <= ue));
    chk({tag, ":fifo_pause"},   32'(bus.fifo_pause),   32'(m_pause));
    chk({tag, ":fifo_error"},   32'(bus.fifo_error),   32'(m_err));
`ifdef FIFO_FWFT_EN
    chk({tag, ":valid_out"},    32'(bus.valid_out),    32'(c != 0));
    chk({tag, ":data_out_pop"}, 32'(bus.data_out_pop), (c != 0) ? 32'(q[0]) : 32'd0);
`else
    chk({tag, ":valid_out"},    32'(bus.valid_out),    32'(m_valid));
    chk({tag, ":data_out_pop"}, 32'(bus.data_out_pop), 32'(m_dout));
`endif
  endtask

  // One clock: apply request, advance the model by the FIFO's rules, then compare.
  task automatic cycle(input string tag, input logic w, input logic r,
                       input logic [DW-1:0] d, input logic clr);
    int c;
    int fthr;
    bit pop_ok, push_ok, err_set;
    bus.write = w; bus.read = r; bus.data_in_push = d; bus.err_clear = clr;
    c       = q.size();
    fthr    = (uf == 0) ? DEPTH : uf;
    pop_ok  = r && (c > 0);
    push_ok = w && ((c < DEPTH) || pop_ok);
    err_set = (w && (c == DEPTH) && !r) || (r && (c == 0));
    m_valid = pop_ok;
    if (pop_ok) m_dout = q.pop_front();
    if (push_ok) q.push_back(d);
    if (err_set) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    c = q.size();
    if (c >= fthr) m_pause = 1'b1;
    else if (c <= ue) m_pause = 1'b0;
    @(posedge clk); #1;
    bus.write = 1'b0; bus.read = 1'b0; bus.err_clear = 1'b0;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1;
    bus.write = 1'b0; bus.read = 1'b0; bus.data_in_push = '0; bus.err_clear = 1'b0;
    set_thr(6, 2);
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    check_all("post_reset");

    // 1: fill
    for (int i = 1; i <= 8; i++) cycle("fill", 1'b1, 1'b0, DW'(i), 1'b0);
    chk("fill_count8", 32'(bus.count), 32'd8);

    // 2: overflow, sticky error, clear
    cycle("overflow", 1'b1, 1'b0, 10'h3FF, 1'b0);
    chk("overflow_err", 32'(bus.fifo_error), 32'd1);
    cycle("idle_sticky", 1'b0, 1'b0, '0, 1'b0);
    cycle("err_clear", 1'b0, 1'b0, '0, 1'b1);
    chk("cleared_err", 32'(bus.fifo_error), 32'd0);

    // 3: drain in order, then underflow
    for (int i = 1; i <= 8; i++) cycle("drain", 1'b0, 1'b1, '0, 1'b0);
    cycle("underflow", 1'b0, 1'b1, '0, 1'b0);
    chk("underflow_err", 32'(bus.fifo_error), 32'd1);
    // new error in the same cycle as err_clear keeps the flag set
    cycle("err_vs_clear", 1'b0, 1'b1, '0, 1'b1);
    cycle("err_clear2", 1'b0, 1'b0, '0, 1'b1);

    // 4: pause hysteresis
    for (int i = 0; i < 6; i++) cycle("hyst_up", 1'b1, 1'b0, DW'(16 + i), 1'b0);
    chk("pause_at6", 32'(bus.fifo_pause), 32'd1);
    for (int i = 0; i < 3; i++) cycle("hyst_dn", 1'b0, 1'b1, '0, 1'b0);
    chk("pause_at3", 32'(bus.fifo_pause), 32'd1);
    cycle("hyst_dn2", 1'b0, 1'b1, '0, 1'b0);
    chk("pause_at2", 32'(bus.fifo_pause), 32'd0);
    for (int i = 0; i < 3; i++) cycle("hyst_up5", 1'b1, 1'b0, DW'(32 + i), 1'b0);
    chk("pause_at5", 32'(bus.fifo_pause), 32'd0);

    // 5: simultaneous push/pop at full, then mixed traffic across wrap
    for (int i = 0; i < 3; i++) cycle("to_full", 1'b1, 1'b0, DW'(48 + i), 1'b0);
    cycle("full_rw", 1'b1, 1'b1, 10'h155, 1'b0);
    chk("full_rw_err", 32'(bus.fifo_error), 32'd0);
    for (int i = 0; i < 20; i++)
      cycle("mixed", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            DW'($urandom_range(0, 1023)), 1'b0);

    // 6: asynchronous reset with count = 5
    while (q.size() > 5) cycle("to5_dn", 1'b0, 1'b1, '0, 1'b0);
    while (q.size() < 5) cycle("to5_up", 1'b1, 1'b0, DW'($urandom_range(0, 1023)), 1'b0);
    chk("pre_reset_count5", 32'(bus.count), 32'd5);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    check_all("async_reset_release");

    // randomized traffic with varying thresholds, including umbral_full = 0
    for (int i = 0; i < 400; i++) begin
      if (i % 40 == 0) set_thr($urandom_range(0, 8), $urandom_range(0, 8));
      cycle("rand", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
            DW'($urandom_range(0, 1023)), 1'($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
